// File: rtl/pll_drp_pkg.sv
// Shared types and constants for the PLLE2_ADV DRP reconfiguration sequencer.
package pll_drp_pkg;

    localparam int unsigned DrpAddrW = 7;
    localparam int unsigned DrpDataW = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        NEXT,
        LOCK_WAIT,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ErrNone        = 2'd0,
        ErrDrpTimeout  = 2'd1,
        ErrLockTimeout = 2'd2
    } err_e;

    typedef struct packed {
        logic [DrpAddrW-1:0] addr;
        logic [DrpDataW-1:0] mask;
        logic [DrpDataW-1:0] data;
        logic                last;
    } drp_entry_t;

    // Mask bits set to 1 keep the current register contents.
    function automatic logic [DrpDataW-1:0] rmw_merge(
        input logic [DrpDataW-1:0] cur,
        input logic [DrpDataW-1:0] mask,
        input logic [DrpDataW-1:0] data
    );
        return (cur & mask) | (data & ~mask);
    endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer cell for asynchronous level inputs.
module prim_flop_2sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/pll_drp_ctrl.sv
// PLLE2_ADV run-time reconfiguration sequencer: holds the PLL in reset,
// read-modify-writes each host entry over DRP, releases reset, waits for lock.
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int unsigned DrpTimeout  = 64,
    parameter int unsigned LockTimeout = 65536,
    parameter int unsigned LockBlank   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [DrpAddrW-1:0] cfg_addr_i,
    input  logic [DrpDataW-1:0] cfg_mask_i,
    input  logic [DrpDataW-1:0] cfg_data_i,
    input  logic                cfg_last_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [1:0]          err_o,
    output logic [DrpAddrW-1:0] drp_daddr_o,
    output logic                drp_den_o,
    output logic                drp_dwe_o,
    output logic [DrpDataW-1:0] drp_di_o,
    input  logic [DrpDataW-1:0] drp_do_i,
    input  logic                drp_drdy_i,
    output logic                pll_rst_o,
    input  logic                pll_locked_i
);

    localparam int unsigned CntMax = (LockTimeout > DrpTimeout) ? LockTimeout : DrpTimeout;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] DrpLimit  = CntW'(DrpTimeout - 1);
    localparam logic [CntW-1:0] LockLimit = CntW'(LockTimeout - 1);
    localparam logic [CntW-1:0] BlankCnt  = CntW'(LockBlank);

    state_e                r_state;
    err_e                  r_err;
    drp_entry_t            r_entry;
    logic [CntW-1:0]       r_cnt;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_den;
    logic                  r_dwe;
    logic [DrpDataW-1:0]   r_di;
    logic                  r_pll_rst;

    logic                  w_locked;
    logic                  w_accept;
    drp_entry_t            w_cfg;
    logic [DrpDataW-1:0]   w_rmw;

    prim_flop_2sync #(
        .Width(1)
    ) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (w_locked)
    );

    assign w_accept = cfg_valid_i && r_ready;
    assign w_cfg    = '{addr: cfg_addr_i, mask: cfg_mask_i, data: cfg_data_i, last: cfg_last_i};
    assign w_rmw    = rmw_merge(drp_do_i, r_entry.mask, r_entry.data);

    // Sequencer FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_err     <= ErrNone;
            r_entry   <= '0;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_den     <= 1'b0;
            r_dwe     <= 1'b0;
            r_di      <= '0;
            r_pll_rst <= 1'b0;
        end else begin
            r_den  <= 1'b0;
            r_dwe  <= 1'b0;
            r_done <= 1'b0;
            // Saturating wait counter; every state entry below clears it.
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + CntW'(1);
            end

            case (r_state)
                IDLE, NEXT: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_entry   <= w_cfg;
                        r_err     <= ErrNone;
                        r_pll_rst <= 1'b1;
                        r_den     <= 1'b1;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    r_cnt   <= '0;
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (drp_drdy_i) begin
                        r_di    <= w_rmw;
                        r_den   <= 1'b1;
                        r_dwe   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= WR_REQ;
                    end else if (r_cnt >= DrpLimit) begin
                        r_err     <= ErrDrpTimeout;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= LOCK_WAIT;
                    end
                end
                WR_REQ: begin
                    r_cnt   <= '0;
                    r_state <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (drp_drdy_i) begin
                        r_cnt <= '0;
                        if (r_entry.last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= LOCK_WAIT;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= NEXT;
                        end
                    end else if (r_cnt >= DrpLimit) begin
                        r_err     <= ErrDrpTimeout;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= LOCK_WAIT;
                    end
                end
                LOCK_WAIT: begin
                    // Early lock is ignored: it may be stale from before the reset pulse.
                    if ((r_cnt >= BlankCnt) && w_locked) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end else if (r_cnt >= LockLimit) begin
                        r_err   <= ErrLockTimeout;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o = r_ready;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign drp_daddr_o = r_entry.addr;
    assign drp_den_o   = r_den;
    assign drp_dwe_o   = r_dwe;
    assign drp_di_o    = r_di;
    assign pll_rst_o   = r_pll_rst;

endmodule
